uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver that replaces the ad-hoc, fixed-format byte receivers used on the debug/console path. It supports configurable data width, parity and stop bits, and includes an input synchroniser, false-start rejection and error flags. Received words leave on a valid/ready stream with a one-entry holding register. It sits between the board-level rxd pin and any consumer, such as a bench monitor or an AXI-Stream bridge into the image-filter SoC.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (100 MHz / 230400); must be >= 4
DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  single clock; all logic is on its rising edge
reset  in  1  synchronous, active-low; sampled on the clk rising edge
rx_i  in  1  asynchronous serial line; idle level is high
m_data  out  DATA_BITS  received word
m_valid  out  1  m_data holds an unconsumed word
m_ready  in  1  consumer accepts the word when m_valid && m_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch
overrun_err  out  1  one-cycle pulse: new word lost because the holding register was full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to IDLE; counters clear; the synchroniser loads 1s; m_valid=0, m_data=0, all error pulses=0, busy=0.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All decisions use rx_s. This adds 2 cycles of latency.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK_WAIT. The counter cnt is clog2(CLKS_PER_BIT) bits wide.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: at cnt==(CLKS_PER_BIT-1)/2, resample the line.
  - rx_s==0: cnt=0, go to DATA.
  - rx_s==1: glitch; return to IDLE and raise no error.
  - Otherwise cnt increments.
- DATA: at cnt==CLKS_PER_BIT-1, sample into shift[bit_idx] and set cnt=0.
  - After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample after CLKS_PER_BIT-1 cycles.
  - The expected bit is the XOR of the data bits for even parity, and its inverse for odd parity.
- STOP: sample each stop bit after CLKS_PER_BIT-1 cycles.
  - Any stop bit low: frame_err pulses, the word is dropped, go to BREAK_WAIT.
  - All stop bits high: go to CLEANUP. If parity failed, parity_err pulses and the word is dropped.
- Word delivery: occurs in the cycle the final stop bit is sampled (mid-bit), so the FSM is back in IDLE before the next start edge.
- CLEANUP: lasts one cycle, then IDLE.
- BREAK_WAIT: stay until rx_s==1, then IDLE. A held-low break therefore yields exactly one frame_err.
- Output register:
  - m_valid is set when a word is delivered, and clears on m_valid && m_ready.
  - If delivery and handshake happen in the same cycle, the new word loads and m_valid stays 1.
  - If delivery arrives while m_valid==1 && !m_ready: the new word is discarded, the old word is retained, and overrun_err pulses.
- m_data is stable while m_valid==1 and !m_ready.
- Reset mid-frame aborts the frame immediately; no partial word and no error is emitted.
- Error pulses are registered and mutually exclusive within a frame.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each sample point (start check, data, parity, stop) takes the 2-of-3 majority of rx_s at cnt = target-1, target and target+1. The decision is made at target+1; the next bit's count is shortened by 1 to keep the bit period exact. Requires CLKS_PER_BIT >= 6.
- Undefined: single sample at target, as specified above.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - the state enum (state_t);
  - parity localparams PAR_NONE/PAR_ODD/PAR_EVEN;
  - function calc_parity(data, mode);
  - function clks_per_bit(clk_hz, baud).
- One sub-module, uart_rx_sync: the 2-flop synchroniser, plus the 3-sample majority window when UART_RX_MAJORITY_EN is defined.
- The FSM and output register stay in uart_rx_param.

Test Plan:
- All tests use CLKS_PER_BIT=8 and m_ready=1 unless stated.
- Default parameters: send 0xA5 with 8N1 -> one m_valid pulse with m_data=0xA5; no errors; busy falls within 8 cycles of the stop-bit midpoint.
- PARITY=2: send 0x3C with parity 0 -> word delivered. Send 0x3D with parity 0 -> parity_err pulse, no m_valid.
- Stop bit driven low for 0x55, then line held low 40 cycles -> exactly one frame_err, FSM in BREAK_WAIT until high, then a following 0x12 is received correctly.
- Start glitch: rx_i low for 2 cycles -> no m_valid, no error, busy returns low.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11 and overrun_err pulses once. Raise m_ready -> 0x11 consumed; m_valid falls.
- Reset asserted mid-DATA of 0xFF, released, then 0x0F sent -> only 0x0F is delivered.
- DATA_BITS=9, STOP_BITS=2, PARITY=1: send 0x1AB -> m_data=0x1AB.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
// Used by uart_rx_param and uart_rx_sync.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CLEANUP,
    S_BREAK
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic calc_parity(
    input logic [8:0] data,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for rx_i.
// UART_RX_MAJORITY_EN adds a 2-of-3 window over the last three rx_s.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_m
);

  logic [1:0] r_sync;

  // Two flops retime the asynchronous line; reset loads idle level
  always_ff @(posedge clk) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_rx};
  end

  assign o_rx_s = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Keep the two previous synchronised samples for the vote
  always_ff @(posedge clk) begin
    if (!reset) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], r_sync[1]};
  end

  assign o_rx_m = (o_rx_s & r_hist[0]) |
                  (o_rx_s & r_hist[1]) |
                  (r_hist[0] & r_hist[1]);
`else
  assign o_rx_m = o_rx_s;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output.
// UART_RX_MAJORITY_EN selects 3-sample majority voting per bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  // Vote completes one cycle after the centre sample; later bits keep
  // exact spacing so only the start check moves.
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2 + MAJ);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LAST_STP = (STOP_BITS == 2);

  logic w_rx_s;
  logic w_rx_m;

  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [BW-1:0]        r_bit, w_bit_n;
  logic                 r_stp, w_stp_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_pbad, w_pbad_n;
  logic                 w_deliver, w_frame, w_par;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr, r_perr, r_oerr;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_rx   (rx_i),
    .o_rx_s (w_rx_s),
    .o_rx_m (w_rx_m)
  );

  // Frame sequencer registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stp   <= 1'b0;
      r_shift <= '0;
      r_pbad  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_stp   <= w_stp_n;
      r_shift <= w_shift_n;
      r_pbad  <= w_pbad_n;
    end
  end

  // Next-state: bit timing, sampling and frame verdict
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_stp_n   = r_stp;
    w_shift_n = r_shift;
    w_pbad_n  = r_pbad;
    w_deliver = 1'b0;
    w_frame   = 1'b0;
    w_par     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n  = '0;
        w_bit_n  = '0;
        w_stp_n  = 1'b0;
        w_pbad_n = 1'b0;
        if (!w_rx_s) w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == MID_CNT) begin
          w_cnt_n   = '0;
          w_state_n = w_rx_m ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_n          = '0;
          w_shift_n[r_bit] = w_rx_m;
          w_bit_n          = r_bit + 1'b1;
          if (r_bit == LAST_BIT)
            w_state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_n   = '0;
          w_pbad_n  = w_rx_m != calc_parity(9'(r_shift), PARITY);
          w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_n = '0;
          if (!w_rx_m) begin
            w_frame   = 1'b1;
            w_state_n = S_BREAK;
          end else if (r_stp == LAST_STP) begin
            w_state_n = S_CLEANUP;
            w_par     = r_pbad;
            w_deliver = !r_pbad;
          end else begin
            w_stp_n = 1'b1;
          end
        end
      end
      S_CLEANUP: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
      S_BREAK: begin
        w_cnt_n = '0;
        if (w_rx_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Holding register, handshake and registered error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_ferr <= w_frame;
      r_perr <= w_par;
      r_oerr <= 1'b0;
      if (w_deliver) begin
        if (r_valid && !m_ready) begin
          r_oerr <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data      = r_data;
  assign m_valid     = r_valid;
  assign frame_err   = r_ferr;
  assign parity_err  = r_perr;
  assign overrun_err = r_oerr;
  assign busy        = r_state != S_IDLE;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into three receiver builds
// (8N1, 8E1, 9O2) checked against an event-queue model.
module tb_uart_rx_param;

  localparam int CPB = 8;
  localparam logic [1:0] K_WORD = 2'd0;
  localparam logic [1:0] K_FRM  = 2'd1;
  localparam logic [1:0] K_PAR  = 2'd2;
  localparam logic [1:0] K_OVR  = 2'd3;

  typedef struct packed {
    logic [1:0] dut;
    logic [1:0] kind;
    logic [8:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rxl, mr, mv, fe, pe, oe, bz;
  logic [7:0] md0, md1;
  logic [8:0] md2;

  ev_t        q[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] mfull;
  logic [8:0] mdata[3];
  logic [8:0] last_word[3];
  int         fe_cnt[3];
  int         pe_cnt[3];
  int         oe_cnt[3];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .reset(reset), .rx_i(rxl[0]),
    .m_data(md0), .m_valid(mv[0]), .m_ready(mr[0]),
    .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun_err(oe[0]), .busy(bz[0]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY(2)) u1 (
    .clk(clk), .reset(reset), .rx_i(rxl[1]),
    .m_data(md1), .m_valid(mv[1]), .m_ready(mr[1]),
    .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun_err(oe[1]), .busy(bz[1]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx_i(rxl[2]),
    .m_data(md2), .m_valid(mv[2]), .m_ready(mr[2]),
    .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun_err(oe[2]), .busy(bz[2]));

  function automatic logic [8:0] mdat(input int d);
    case (d)
      0:       return {1'b0, md0};
      1:       return {1'b0, md1};
      default: return md2;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic observe(input int d,
                         input logic [1:0] k,
                         input logic [8:0] v);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: dut=%0d kind=%0d data=%0h want none",
               d, k, v);
    end else begin
      e = q.pop_front();
      chk("event_dut", d, 32'(e.dut));
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_data", 32'(v), 32'(e.data));
    end
  endtask

  task automatic monitor();
    logic [8:0] pdata[3];
    logic [2:0] phold;
    logic [8:0] cur;
    phold = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        cur = mdat(d);
        if (phold[d] && mv[d]) chk("hold_stable", 32'(cur), 32'(pdata[d]));
        phold[d] = mv[d] && !mr[d];
        pdata[d] = cur;
        if (mv[d] && mr[d]) begin
          last_word[d] = cur;
          observe(d, K_WORD, cur);
        end
        if (fe[d]) begin fe_cnt[d]++; observe(d, K_FRM, 9'd0); end
        if (pe[d]) begin pe_cnt[d]++; observe(d, K_PAR, 9'd0); end
        if (oe[d]) begin oe_cnt[d]++; observe(d, K_OVR, 9'd0); end
      end
    end
  endtask

  task automatic push(input int d, input logic [1:0] k,
                      input logic [8:0] v);
    ev_t e;
    e.dut  = 2'(d);
    e.kind = k;
    e.data = v;
    q.push_back(e);
  endtask

  // pf < 0: send the correct parity bit, else send pf[0]
  task automatic send(input int d, input logic [8:0] w,
                      input int pf, input bit sl);
    int   nbits, mode, nstop, ones, nb;
    logic pok, psent;
    logic bits[16];
    nbits = (d == 2) ? 9 : 8;
    mode  = (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    nstop = (d == 2) ? 2 : 1;
    ones  = 0;
    nb    = 0;
    bits[nb] = 1'b0;
    nb = nb + 1;
    for (int i = 0; i < nbits; i++) begin
      bits[nb] = w[i];
      nb = nb + 1;
      ones = ones + int'(w[i]);
    end
    pok   = (mode == 2) ? ones[0] : ~ones[0];
    psent = (pf < 0) ? pok : pf[0];
    if (mode != 0) begin
      bits[nb] = psent;
      nb = nb + 1;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[nb] = !(sl && s == 0);
      nb = nb + 1;
    end
    if (sl) push(d, K_FRM, 9'd0);
    else if (mode != 0 && psent != pok) push(d, K_PAR, 9'd0);
    else if (mfull[d] && !mr[d]) push(d, K_OVR, 9'd0);
    else if (mr[d]) push(d, K_WORD, w);
    else begin
      mfull[d] = 1'b1;
      mdata[d] = w;
    end
    for (int i = 0; i < nb; i++) begin
      rxl[d] = bits[i];
      wait_cyc(CPB);
    end
    if (!sl) rxl[d] = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      wait_cyc(1);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    reset = 1'b0;
    rxl   = '1;
    mr    = '1;
    mfull = '0;
    for (int d = 0; d < 3; d++) begin
      last_word[d] = '0;
      mdata[d]     = '0;
    end
    fork
      monitor();
    join_none
    wait_cyc(3);
    chk("rst_valid", 32'(mv), 0);
    chk("rst_busy", 32'(bz), 0);
    chk("rst_errs", 32'({fe, pe, oe}), 0);
    chk("rst_data0", 32'(md0), 0);
    chk("rst_data2", 32'(md2), 0);
    reset = 1'b1;
    wait_cyc(3);

    send(0, 9'h0A5, -1, 1'b0);
    wait_cyc(4);
    chk("a5_busy_low", 32'(bz[0]), 0);
    drain("a5_drain");
    chk("a5_word", 32'(last_word[0]), 32'h0A5);

    send(1, 9'h03C, -1, 1'b0);
    drain("3c_drain");
    chk("3c_word", 32'(last_word[1]), 32'h03C);
    send(1, 9'h03D, 0, 1'b0);
    drain("3d_drain");
    chk("3d_perr", pe_cnt[1], 1);
    chk("3d_no_word", 32'(last_word[1]), 32'h03C);

    send(0, 9'h055, -1, 1'b1);
    wait_cyc(30);
    chk("break_busy", 32'(bz[0]), 1);
    wait_cyc(10);
    rxl[0] = 1'b1;
    wait_cyc(6);
    chk("break_idle", 32'(bz[0]), 0);
    chk("break_ferr", fe_cnt[0], 1);
    send(0, 9'h012, -1, 1'b0);
    drain("12_drain");
    chk("12_word", 32'(last_word[0]), 32'h012);

    rxl[0] = 1'b0;
    wait_cyc(2);
    rxl[0] = 1'b1;
    wait_cyc(2);
    chk("glitch_busy", 32'(bz[0]), 1);
    wait_cyc(12);
    chk("glitch_idle", 32'(bz[0]), 0);
    drain("glitch_drain");
    chk("glitch_ferr", fe_cnt[0], 1);

    mr[0] = 1'b0;
    send(0, 9'h011, -1, 1'b0);
    send(0, 9'h022, -1, 1'b0);
    drain("ovr_drain");
    chk("ovr_count", oe_cnt[0], 1);
    chk("ovr_keep", 32'(md0), 32'h11);
    chk("ovr_valid", 32'(mv[0]), 1);
    push(0, K_WORD, mdata[0]);
    mfull[0] = 1'b0;
    mr[0] = 1'b1;
    wait_cyc(2);
    drain("ovr_take");
    chk("ovr_valid_low", 32'(mv[0]), 0);
    chk("ovr_word", 32'(last_word[0]), 32'h011);

    rxl[0] = 1'b0;
    wait_cyc(CPB);
    rxl[0] = 1'b1;
    wait_cyc(20);
    chk("mid_busy", 32'(bz[0]), 1);
    reset = 1'b0;
    mfull = '0;
    wait_cyc(2);
    chk("mid_rst_busy", 32'(bz), 0);
    chk("mid_rst_valid", 32'(mv), 0);
    reset = 1'b1;
    wait_cyc(10);
    send(0, 9'h00F, -1, 1'b0);
    drain("0f_drain");
    chk("0f_word", 32'(last_word[0]), 32'h00F);

    send(2, 9'h1AB, -1, 1'b0);
    drain("1ab_drain");
    chk("1ab_word", 32'(last_word[2]), 32'h1AB);
    send(2, 9'h1AB, 1, 1'b0);
    drain("1ab_p1_drain");
    send(2, 9'h0FF, 0, 1'b0);
    drain("0ff_drain");
    chk("0ff_perr", pe_cnt[2], 1);

    wait_cyc(20);
    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
